// File: rtl/acc_bank.sv
// NUM_CH independent WIDTH-bit accumulators (load / ALU load / add / inc, wrap or saturate, sticky ovf)
// plus a snapshot drain sequencer: one beat per cycle, data held stable while drain_ready is low.
module acc_bank #(
  parameter int WIDTH    = 16,
  parameter int NUM_CH   = 4,
  parameter int SAT_EN   = 0,
  parameter int INC_STEP = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*WIDTH-1:0]   dataIn,
  input  logic [NUM_CH*WIDTH-1:0]   aluIn,
  input  logic [NUM_CH-1:0]         write_en,
  input  logic [NUM_CH-1:0]         alu_en,
  input  logic [NUM_CH-1:0]         acc_en,
  input  logic [NUM_CH-1:0]         inc_en,
  input  logic [NUM_CH-1:0]         clear_ovf,
  output logic [NUM_CH*WIDTH-1:0]   dataOut,
  output logic [NUM_CH-1:0]         ovf,
  input  logic                      drain_start,
  output logic                      drain_valid,
  input  logic                      drain_ready,
  output logic [WIDTH-1:0]          drain_data,
  output logic [$clog2(NUM_CH)-1:0] drain_ch,
  output logic                      drain_last,
  output logic                      busy
);

  localparam int                CW       = $clog2(NUM_CH);
  localparam logic [WIDTH:0]    STEP     = (WIDTH+1)'(INC_STEP);
  localparam logic [CW-1:0]     LAST_IDX = CW'(NUM_CH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [WIDTH-1:0]  acc_q  [NUM_CH];
  logic [WIDTH-1:0]  acc_d  [NUM_CH];
  logic [WIDTH-1:0]  snap_q [NUM_CH];
  logic [WIDTH-1:0]  snap_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [CW-1:0]     idx_q, idx_d;
  state_t            state_q, state_d;
  logic [WIDTH:0]    sum;
  logic              add_op;

  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q & ~clear_ovf;
    sum    = '0;
    add_op = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum    = '0;
      add_op = 1'b0;
      if (write_en[i]) begin
        acc_d[i] = dataIn[i*WIDTH +: WIDTH];
      end else if (alu_en[i]) begin
        acc_d[i] = aluIn[i*WIDTH +: WIDTH];
      end else if (acc_en[i]) begin
        sum    = {1'b0, acc_q[i]} + {1'b0, aluIn[i*WIDTH +: WIDTH]};
        add_op = 1'b1;
      end else if (inc_en[i]) begin
        sum    = {1'b0, acc_q[i]} + STEP;
        add_op = 1'b1;
      end
      // A carry sets ovf after the clear above, so a same-cycle overflow wins.
      if (add_op) begin
        if (sum[WIDTH]) begin
          ovf_d[i] = 1'b1;
          acc_d[i] = (SAT_EN != 0) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        end else begin
          acc_d[i] = sum[WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    drain_valid = 1'b0;
    drain_data  = '0;
    drain_ch    = idx_q;
    drain_last  = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        if (drain_start) begin
          snap_d  = acc_q;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        drain_valid = 1'b1;
        busy        = 1'b1;
        drain_data  = snap_q[idx_q];
        drain_last  = (idx_q == LAST_IDX);
        if (drain_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      ovf_q   <= '0;
      idx_q   <= '0;
      state_q <= IDLE;
    end else begin
      acc_q   <= acc_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign dataOut[g*WIDTH +: WIDTH] = acc_q[g];
  end
  assign ovf = ovf_q;

endmodule

// File: tb/tb_acc_bank.sv
// Drives a wrapping and a saturating acc_bank with the same stimulus and checks both
// against a queue/array reference model, directed scenarios first and then random traffic.
module tb_acc_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] data_in, alu_in;
  logic [3:0]  we, ae, ce, ie, co;
  logic        ds, dr;

  logic [63:0] dout_w, dout_s;
  logic [3:0]  ovf_w, ovf_s;
  logic        dv_w, dv_s, dl_w, dl_s, bz_w, bz_s;
  logic [15:0] dd_w, dd_s;
  logic [1:0]  dc_w, dc_s;

  int errors = 0;
  int checks = 0;

  int unsigned m_acc  [2][4];
  bit          m_ovf  [2][4];
  int unsigned m_snap [2][4];
  int          q_ch   [$];

  always #5 clk = ~clk;

  acc_bank #(.WIDTH(16), .NUM_CH(4), .SAT_EN(0), .INC_STEP(1)) dut_w (
    .clk(clk), .rst(rst), .dataIn(data_in), .aluIn(alu_in),
    .write_en(we), .alu_en(ae), .acc_en(ce), .inc_en(ie), .clear_ovf(co),
    .dataOut(dout_w), .ovf(ovf_w), .drain_start(ds), .drain_valid(dv_w),
    .drain_ready(dr), .drain_data(dd_w), .drain_ch(dc_w), .drain_last(dl_w), .busy(bz_w)
  );

  acc_bank #(.WIDTH(16), .NUM_CH(4), .SAT_EN(1), .INC_STEP(1)) dut_s (
    .clk(clk), .rst(rst), .dataIn(data_in), .aluIn(alu_in),
    .write_en(we), .alu_en(ae), .acc_en(ce), .inc_en(ie), .clear_ovf(co),
    .dataOut(dout_s), .ovf(ovf_s), .drain_start(ds), .drain_valid(dv_s),
    .drain_ready(dr), .drain_data(dd_s), .drain_ch(dc_s), .drain_last(dl_s), .busy(bz_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned lane(input logic [63:0] v, input int i);
    return int'(v[i*16 +: 16]);
  endfunction

  function automatic logic [3:0] rbits(input int pct);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 99) < pct);
    return r;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        m_acc[d][i]  = 0;
        m_ovf[d][i]  = 0;
        m_snap[d][i] = 0;
      end
    q_ch.delete();
  endtask

  // Next state of the reference model from the inputs present at a rising edge.
  task automatic model_edge();
    bit          start;
    int unsigned sum;
    if (rst) begin
      m_reset();
      return;
    end
    start = (q_ch.size() == 0) && ds;
    if (q_ch.size() != 0 && dr) void'(q_ch.pop_front());
    if (start) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++) m_snap[d][i] = m_acc[d][i];
      for (int i = 0; i < 4; i++) q_ch.push_back(i);
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        if (co[i]) m_ovf[d][i] = 0;
        if (we[i]) m_acc[d][i] = lane(data_in, i);
        else if (ae[i]) m_acc[d][i] = lane(alu_in, i);
        else if (ce[i] || ie[i]) begin
          sum = m_acc[d][i] + (ce[i] ? lane(alu_in, i) : 1);
          if (sum > 65535) begin
            m_ovf[d][i] = 1;
            m_acc[d][i] = (d == 1) ? 65535 : sum - 65536;
          end else begin
            m_acc[d][i] = sum;
          end
        end
      end
  endtask

  task automatic check_dut(input int d, input logic [63:0] dout, input logic [3:0] ov,
                           input logic dv, input logic [15:0] dd, input logic [1:0] dc,
                           input logic dl, input logic bz);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d%0d_acc%0d", d, i), 32'(dout[i*16 +: 16]), m_acc[d][i]);
      chk($sformatf("d%0d_ovf%0d", d, i), 32'(ov[i]), 32'(m_ovf[d][i]));
    end
    chk($sformatf("d%0d_valid", d), 32'(dv), 32'(q_ch.size() != 0));
    chk($sformatf("d%0d_busy", d), 32'(bz), 32'(q_ch.size() != 0));
    if (q_ch.size() != 0) begin
      chk($sformatf("d%0d_dch", d), 32'(dc), q_ch[0]);
      chk($sformatf("d%0d_ddata", d), 32'(dd), m_snap[d][q_ch[0]]);
      chk($sformatf("d%0d_dlast", d), 32'(dl), 32'(q_ch.size() == 1));
    end else begin
      chk($sformatf("d%0d_dlast_idle", d), 32'(dl), 32'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_dut(0, dout_w, ovf_w, dv_w, dd_w, dc_w, dl_w, bz_w);
    check_dut(1, dout_s, ovf_s, dv_s, dd_s, dc_s, dl_s, bz_s);
  endtask

  task automatic clear_in();
    data_in = '0; alu_in = '0;
    we = '0; ae = '0; ce = '0; ie = '0; co = '0;
    ds = 1'b0; dr = 1'b0;
  endtask

  task automatic rand_in();
    data_in = {$urandom(), $urandom()};
    alu_in  = {$urandom(), $urandom()};
    we = rbits(10); ae = rbits(10); ce = rbits(30); ie = rbits(30); co = rbits(10);
    ds = ($urandom_range(0, 99) < 20);
    dr = ($urandom_range(0, 99) < 70);
  endtask

  initial begin
    clear_in();
    m_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_dout", dout_w[31:0], 32'd0);
    chk("rst_valid", 32'(dv_w), 32'd0);
    chk("rst_busy", 32'(bz_s), 32'd0);
    chk("rst_ddata", 32'(dd_w), 32'd0);
    for (int k = 0; k < 5; k++) begin
      rand_in();
      cycle();
    end
    rst = 1'b0;
    clear_in();
    cycle();

    // Priority on channel 0
    we[0] = 1; ae[0] = 1; ie[0] = 1;
    data_in = 64'd30; alu_in = 64'd300;
    cycle();
    chk("prio_write", 32'(dout_w[15:0]), 32'd30);
    clear_in(); ae[0] = 1; alu_in = 64'd250;
    cycle();
    chk("prio_alu", 32'(dout_w[15:0]), 32'd250);
    clear_in(); ce[0] = 1; alu_in = 64'd100;
    cycle();
    chk("prio_acc", 32'(dout_w[15:0]), 32'd350);
    clear_in(); ie[0] = 1;
    cycle();
    chk("prio_inc", 32'(dout_w[15:0]), 32'd351);
    chk("prio_others", dout_w[47:16], 32'd0);

    // Overflow, wrap vs saturate
    clear_in(); we[0] = 1; data_in = 64'hFFFE;
    cycle();
    clear_in(); ie[0] = 1;
    cycle();
    chk("ovf_inc1_w", 32'(dout_w[15:0]), 32'hFFFF);
    chk("ovf_inc1_flag", 32'(ovf_w[0]), 32'd0);
    cycle();
    chk("ovf_inc2_w", 32'(dout_w[15:0]), 32'h0000);
    chk("ovf_inc2_s", 32'(dout_s[15:0]), 32'hFFFF);
    chk("ovf_inc2_flag_w", 32'(ovf_w[0]), 32'd1);
    chk("ovf_inc2_flag_s", 32'(ovf_s[0]), 32'd1);
    clear_in(); co[0] = 1;
    cycle();
    chk("ovf_clear", 32'(ovf_w[0]), 32'd0);
    clear_in(); we[0] = 1; data_in = 64'hFFF0;
    cycle();
    clear_in(); ce[0] = 1; alu_in = 64'h0020;
    cycle();
    chk("ovf_acc_w", 32'(dout_w[15:0]), 32'h0010);
    chk("ovf_acc_s", 32'(dout_s[15:0]), 32'hFFFF);
    clear_in(); ce[0] = 1; co[0] = 1; alu_in = 64'hFFF0;
    cycle();
    chk("ovf_set_wins_w", 32'(ovf_w[0]), 32'd1);
    chk("ovf_set_wins_s", 32'(ovf_s[0]), 32'd1);

    // Drain with backpressure, live write and ignored start
    clear_in(); we = 4'hF;
    data_in = {16'd40, 16'd30, 16'd20, 16'd10};
    cycle();
    clear_in(); ds = 1;
    cycle();
    chk("drn_b0_ch", 32'(dc_w), 32'd0);
    chk("drn_b0_data", 32'(dd_w), 32'd10);
    clear_in(); dr = 1; ds = 1; we[2] = 1; data_in = 64'd99 << 32;
    cycle();
    chk("drn_b1_data", 32'(dd_w), 32'd20);
    chk("drn_live99", 32'(dout_w[47:32]), 32'd99);
    clear_in();
    cycle();
    chk("drn_stall_data", 32'(dd_w), 32'd20);
    chk("drn_stall_ch", 32'(dc_w), 32'd1);
    dr = 1;
    cycle();
    chk("drn_b2_data", 32'(dd_s), 32'd30);
    chk("drn_b2_last", 32'(dl_w), 32'd0);
    cycle();
    chk("drn_b3_data", 32'(dd_w), 32'd40);
    chk("drn_b3_last", 32'(dl_w), 32'd1);

    // Back-to-back: start on final transfer ignored, next cycle accepted
    ds = 1;
    cycle();
    chk("b2b_ignored", 32'(dv_w), 32'd0);
    cycle();
    chk("b2b_new_valid", 32'(dv_w), 32'd1);
    chk("b2b_new_data", 32'(dd_w), 32'd10);
    ds = 0;
    for (int k = 0; k < 4; k++) cycle();
    chk("b2b_done", 32'(bz_w), 32'd0);

    // Reset mid-drain
    ds = 1; dr = 1;
    cycle();
    ds = 0;
    cycle();
    cycle();
    chk("rmd_ch_before", 32'(dc_w), 32'd2);
    rst = 1'b1;
    #1;
    chk("rmd_valid_w", 32'(dv_w), 32'd0);
    chk("rmd_valid_s", 32'(dv_s), 32'd0);
    chk("rmd_busy", 32'(bz_w), 32'd0);
    chk("rmd_dout", dout_w[31:0], 32'd0);
    m_reset();
    cycle();
    cycle();
    rst = 1'b0;
    clear_in(); ds = 1;
    cycle();
    chk("rmd_redrain_ch", 32'(dc_w), 32'd0);
    chk("rmd_redrain_data", 32'(dd_w), 32'd0);
    ds = 0; dr = 1;
    for (int k = 0; k < 4; k++) cycle();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      rand_in();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
